// File: rtl/axi_wr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_req_arbiter
// Brief    : Round-robin arbiter sharing one AXI write state core between
//            CH write requesters.
// Revision : 1.0  initial release
// ============================================================================
module axi_wr_req_arbiter #(
    parameter int CH    = 4,
    parameter int LSIZE = 10,
    parameter int ASIZE = 32,
    parameter int IDXW  = 2
) (
    input  logic                  axi_aclk,
    input  logic                  axi_reset,
    input  logic [CH-1:0]         ch_req,
    input  logic [CH*LSIZE-1:0]   ch_len,
    input  logic [CH*ASIZE-1:0]   ch_addr,
    output logic [CH-1:0]         ch_grant,
    output logic [CH-1:0]         ch_done,
    output logic [CH-1:0]         ch_err,
    output logic [CH-1:0]         ch_pull_en,
    output logic                  core_write_req,
    output logic [LSIZE-1:0]      core_req_len,
    output logic [ASIZE-1:0]      core_req_addr,
    input  logic                  core_req_resp,
    input  logic                  core_req_done,
    input  logic                  core_pull_data_en,
    input  logic                  core_pend_out,
    input  logic                  ext_pend_in,
    output logic                  core_pend_in,
    output logic                  busy,
    output logic [IDXW-1:0]       cur_ch
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_BUSY  = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    logic [2:0]       r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_cur;
    logic [LSIZE-1:0] r_len;
    logic [ASIZE-1:0] r_addr;
    logic             r_first;
    logic             r_pend_prev;

    logic             w_any;
    logic [IDXW-1:0]  w_win;
    logic [LSIZE-1:0] w_win_len;
    logic [ASIZE-1:0] w_win_addr;
    int               w_best_dist;
    int               w_dist;
    logic             w_pend_fall;
    logic [CH-1:0]    w_cur_oh;

    // Distance 0 is the channel just after the last served one; the
    // nearest requester in that rotating order wins.
    always_comb begin
        w_any       = 1'b0;
        w_win       = '0;
        w_win_len   = '0;
        w_win_addr  = '0;
        w_best_dist = CH;
        w_dist      = 0;
        for (int i = 0; i < CH; i++) begin
            if (i > int'(r_ptr)) begin
                w_dist = i - int'(r_ptr) - 1;
            end else begin
                w_dist = i + CH - 1 - int'(r_ptr);
            end
            if (ch_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_any       = 1'b1;
                w_win       = IDXW'(i);
                w_win_len   = ch_len[i*LSIZE +: LSIZE];
                w_win_addr  = ch_addr[i*ASIZE +: ASIZE];
            end
        end
    end

    // Core signals an error response by leaving busy without a done pulse.
    assign w_pend_fall = r_pend_prev && !core_pend_out && !core_req_done;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= IDXW'(CH - 1);
            r_cur       <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_first     <= 1'b0;
            r_pend_prev <= 1'b0;
        end else begin
            r_pend_prev <= core_pend_out;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_cur   <= w_win;
                        r_len   <= w_win_len;
                        r_addr  <= w_win_addr;
                        r_first <= (w_win_len != '0);
                        r_state <= (w_win_len == '0) ? c_ST_ERR : c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_first <= 1'b0;
                    if (core_req_resp) begin
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (core_req_done) begin
                        r_state <= c_ST_DONE;
                    end else if (w_pend_fall) begin
                        r_state <= c_ST_ERR;
                    end
                end
                c_ST_DONE, c_ST_ERR: begin
                    r_ptr   <= r_cur;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_cur_oh = {{(CH-1){1'b0}}, 1'b1} << r_cur;

    assign ch_grant       = (r_state == c_ST_ISSUE && r_first) ? w_cur_oh : '0;
    assign ch_done        = (r_state == c_ST_DONE) ? w_cur_oh : '0;
    assign ch_err         = (r_state == c_ST_ERR)  ? w_cur_oh : '0;
    assign ch_pull_en     = (r_state == c_ST_BUSY && core_pull_data_en) ? w_cur_oh : '0;
    assign core_write_req = (r_state == c_ST_ISSUE);
    assign core_req_len   = r_len;
    assign core_req_addr  = r_addr;
    assign core_pend_in   = ext_pend_in;
    assign busy           = (r_state != c_ST_IDLE);
    assign cur_ch         = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_req_arbiter
// Brief    : Scoreboard bench for axi_wr_req_arbiter with a behavioural core.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_wr_req_arbiter;

    localparam int CH    = 4;
    localparam int LSIZE = 10;
    localparam int ASIZE = 32;
    localparam int IDXW  = 2;

    logic                axi_aclk = 1'b0;
    logic                axi_reset;
    logic [CH-1:0]       ch_req;
    logic [CH*LSIZE-1:0] ch_len;
    logic [CH*ASIZE-1:0] ch_addr;
    logic [CH-1:0]       ch_grant, ch_done, ch_err, ch_pull_en;
    logic                core_write_req;
    logic [LSIZE-1:0]    core_req_len;
    logic [ASIZE-1:0]    core_req_addr;
    logic                core_req_resp, core_req_done, core_pull_data_en, core_pend_out;
    logic                ext_pend_in, core_pend_in, busy;
    logic [IDXW-1:0]     cur_ch;

    axi_wr_req_arbiter #(.CH(CH), .LSIZE(LSIZE), .ASIZE(ASIZE), .IDXW(IDXW)) u_dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset), .ch_req(ch_req), .ch_len(ch_len),
        .ch_addr(ch_addr), .ch_grant(ch_grant), .ch_done(ch_done), .ch_err(ch_err),
        .ch_pull_en(ch_pull_en), .core_write_req(core_write_req), .core_req_len(core_req_len),
        .core_req_addr(core_req_addr), .core_req_resp(core_req_resp),
        .core_req_done(core_req_done), .core_pull_data_en(core_pull_data_en),
        .core_pend_out(core_pend_out), .ext_pend_in(ext_pend_in),
        .core_pend_in(core_pend_in), .busy(busy), .cur_ch(cur_ch)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        int          kind;   // 0 grant, 1 done, 2 err
        int          ch;
        logic [31:0] addr;
        int          len;
        int          beats;
        int          min_rc;
        int          max_rc;
    } ev_t;

    ev_t exp_q[$];
    int  rd_ptr = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  req_total[CH];
    int  granted[CH];
    logic got_grant[CH];
    logic err_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [CH-1:0] onehot(input int c);
        logic [CH-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic set_ch(input int c, input logic [31:0] a, input int l);
        ch_addr[c*ASIZE +: ASIZE] = a;
        ch_len[c*LSIZE +: LSIZE]  = LSIZE'(l);
    endtask

    task automatic push_g(input int c, input logic [31:0] a, input int l);
        ev_t e;
        e = '{kind: 0, ch: c, addr: a, len: l, beats: 0, min_rc: 0, max_rc: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int k, input int c, input int b, input int mn, input int mx);
        ev_t e;
        e = '{kind: k, ch: c, addr: 32'h0, len: 0, beats: b, min_rc: mn, max_rc: mx};
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(rd_ptr == exp_q.size() && !busy && ch_req == '0)) begin
            @(negedge axi_aclk);
            n++;
        end
        chk({tag, "_drained"}, 64'(n < budget), 64'(1));
        chk({tag, "_busy_low"}, 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(ch_grant), 64'(0));
        chk({tag, "_done"}, 64'(ch_done), 64'(0));
        chk({tag, "_err"}, 64'(ch_err), 64'(0));
        chk({tag, "_pull"}, 64'(ch_pull_en), 64'(0));
        chk({tag, "_wreq"}, 64'(core_write_req), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_cur"}, 64'(cur_ch), 64'(0));
        chk({tag, "_len"}, 64'(core_req_len), 64'(0));
        chk({tag, "_addr"}, 64'(core_req_addr), 64'(0));
    endtask

    initial forever begin
        @(posedge axi_aclk);
        cyc++;
    end

    // Requesters: hold ch_req until granted (or rejected without a grant).
    initial begin
        ch_req = '0;
        for (int i = 0; i < CH; i++) begin
            granted[i]   = 0;
            got_grant[i] = 1'b0;
        end
        forever begin
            @(posedge axi_aclk);
            #1;
            for (int i = 0; i < CH; i++) begin
                if (axi_reset) begin
                    granted[i]   = req_total[i];
                    got_grant[i] = 1'b0;
                end else begin
                    if (ch_grant[i]) begin
                        granted[i]++;
                        got_grant[i] = 1'b1;
                    end
                    if (ch_err[i] && !got_grant[i]) granted[i]++;
                    if (ch_err[i] || ch_done[i]) got_grant[i] = 1'b0;
                end
                ch_req[i] = (granted[i] < req_total[i]);
            end
        end
    end

    // Behavioural write core: accept one cycle after seeing the request,
    // stream len beats, then done (or drop busy silently in error mode).
    initial begin
        int cst;
        int beats_left;
        logic err_l;
        cst = 0; beats_left = 0; err_l = 1'b0;
        core_req_resp = 0; core_req_done = 0; core_pull_data_en = 0; core_pend_out = 0;
        forever begin
            @(posedge axi_aclk);
            #1;
            core_req_resp = 0; core_req_done = 0; core_pull_data_en = 0;
            if (axi_reset) begin
                cst = 0;
                core_pend_out = 0;
            end else begin
                case (cst)
                    0: if (core_write_req && !ext_pend_in) cst = 1;
                    1: begin
                        core_req_resp = 1;
                        core_pend_out = 1;
                        beats_left    = int'(core_req_len);
                        err_l         = err_mode;
                        cst           = 2;
                    end
                    default: begin
                        if (beats_left > 0) begin
                            core_pull_data_en = 1;
                            beats_left--;
                        end else begin
                            core_pend_out = 0;
                            if (!err_l) core_req_done = 1;
                            cst = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every grant/done/err pulse.
    initial begin
        int   owner, beats, req_cyc, done_cyc;
        ev_t  e;
        owner = 0; beats = 0; req_cyc = 0; done_cyc = -100;
        forever begin
            @(negedge axi_aclk);
            if (axi_reset) begin
                rd_ptr  = exp_q.size();
                beats   = 0;
                req_cyc = 0;
            end else begin
                if (|ch_grant) begin
                    if (rd_ptr >= exp_q.size()) begin
                        chk("unexpected_grant", 64'(ch_grant), 64'(0));
                    end else begin
                        e = exp_q[rd_ptr];
                        rd_ptr++;
                        chk("grant_kind", 64'(0), 64'(e.kind));
                        chk("grant_onehot", 64'(ch_grant), 64'(onehot(e.ch)));
                        chk("grant_cur_ch", 64'(cur_ch), 64'(e.ch));
                        chk("grant_addr", 64'(core_req_addr), 64'(e.addr));
                        chk("grant_len", 64'(core_req_len), 64'(e.len));
                        chk("grant_wreq", 64'(core_write_req), 64'(1));
                        owner = e.ch;
                    end
                    beats   = 0;
                    req_cyc = 0;
                end
                if (core_write_req) req_cyc++;
                if (|ch_pull_en) begin
                    chk("pull_owner", 64'(ch_pull_en), 64'(onehot(owner)));
                    beats++;
                end
                if (core_req_done) done_cyc = cyc;
                if ((|ch_done) || (|ch_err)) begin
                    if (rd_ptr >= exp_q.size()) begin
                        chk("unexpected_end", 64'({ch_done, ch_err}), 64'(0));
                    end else begin
                        e = exp_q[rd_ptr];
                        rd_ptr++;
                        chk("end_kind", 64'((|ch_done) ? 1 : 2), 64'(e.kind));
                        chk("end_onehot", 64'((|ch_done) ? ch_done : ch_err), 64'(onehot(e.ch)));
                        chk("end_beats", 64'(beats), 64'(e.beats));
                        chk("end_wreq_cycles", 64'(req_cyc >= e.min_rc && req_cyc <= e.max_rc), 64'(1));
                        if (|ch_done) chk("done_latency", 64'(cyc - done_cyc), 64'(1));
                    end
                    beats   = 0;
                    req_cyc = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        axi_reset   = 1'b1;
        ext_pend_in = 1'b0;
        ch_len      = '0;
        ch_addr     = '0;
        for (int i = 0; i < CH; i++) req_total[i] = 0;
        repeat (3) @(negedge axi_aclk);
        check_all_zero("reset");
        chk("reset_pend_pass", 64'(core_pend_in), 64'(0));
        axi_reset = 1'b0;
        @(negedge axi_aclk);

        // Single channel: ch0 addr 0x1000, len 16
        set_ch(0, 32'h1000, 16);
        push_g(0, 32'h1000, 16);
        push_end(1, 0, 16, 2, 2);
        req_total[0]++;
        n = 0;
        do begin @(negedge axi_aclk); n++; end while (!ch_grant[0] && n < 20);
        chk("t1_grant_latency", 64'(n), 64'(2));
        drain("t1", 200);

        // Four channels at once from reset: order 0,1,2,3,0
        axi_reset = 1'b1;
        repeat (2) @(negedge axi_aclk);
        axi_reset = 1'b0;
        for (int i = 0; i < CH; i++) begin
            set_ch(i, 32'h2000 + 32'(i) * 32'h100, 4 + i);
            push_g(i, 32'h2000 + 32'(i) * 32'h100, 4 + i);
            push_end(1, i, 4 + i, 2, 2);
        end
        push_g(0, 32'h2000, 4);
        push_end(1, 0, 4, 2, 2);
        req_total[0] += 2;
        for (int i = 1; i < CH; i++) req_total[i]++;
        drain("t2", 500);

        // Zero-length request on ch2: error, core never asked
        set_ch(2, 32'h3000, 0);
        push_end(2, 2, 0, 0, 0);
        req_total[2]++;
        n = 0;
        do begin @(negedge axi_aclk); n++; end while (!ch_err[2] && n < 20);
        chk("t3_err_latency", 64'(n), 64'(2));
        drain("t3", 50);

        // Error response on ch1, then a normal request on ch1
        err_mode = 1'b1;
        set_ch(1, 32'h4000, 8);
        push_g(1, 32'h4000, 8);
        push_end(2, 1, 8, 2, 2);
        req_total[1]++;
        drain("t4a", 200);
        err_mode = 1'b0;
        set_ch(1, 32'h4400, 5);
        push_g(1, 32'h4400, 5);
        push_end(1, 1, 5, 2, 2);
        req_total[1]++;
        drain("t4b", 200);

        // External hold for 20 cycles on ch3
        ext_pend_in = 1'b1;
        set_ch(3, 32'h5000, 6);
        push_g(3, 32'h5000, 6);
        push_end(1, 3, 6, 21, 40);
        req_total[3]++;
        n = 0;
        do begin @(negedge axi_aclk); n++; end while (!ch_grant[3] && n < 20);
        chk("t5_grant_seen", 64'(ch_grant[3]), 64'(1));
        repeat (20) @(negedge axi_aclk);
        chk("t5_wreq_held", 64'(core_write_req), 64'(1));
        chk("t5_pend_pass", 64'(core_pend_in), 64'(1));
        chk("t5_no_pull", 64'(ch_pull_en), 64'(0));
        chk("t5_cur_ch", 64'(cur_ch), 64'(3));
        ext_pend_in = 1'b0;
        drain("t5", 200);

        // Reset mid-burst on ch0, then ch0 wins over ch1
        set_ch(0, 32'h6000, 32);
        push_g(0, 32'h6000, 32);
        req_total[0]++;
        n = 0;
        do begin @(negedge axi_aclk); n++; end while (!ch_pull_en[0] && n < 40);
        chk("t6_mid_burst", 64'(ch_pull_en[0]), 64'(1));
        axi_reset = 1'b1;
        @(negedge axi_aclk);
        check_all_zero("t6_reset");
        axi_reset = 1'b0;
        @(negedge axi_aclk);
        set_ch(0, 32'h6100, 3);
        set_ch(1, 32'h6200, 3);
        push_g(0, 32'h6100, 3);
        push_end(1, 0, 3, 2, 2);
        push_g(1, 32'h6200, 3);
        push_end(1, 1, 3, 2, 2);
        req_total[0]++;
        req_total[1]++;
        drain("t6", 200);

        repeat (3) @(negedge axi_aclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
